// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 device-side transmitter: prefix bytes,
// arrow scan codes, the sequencer state type and the frame builder.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BREAK = 8'hF0;

    localparam logic [7:0] LEFT  = 8'h6B;
    localparam logic [7:0] RIGHT = 8'h74;
    localparam logic [7:0] UP    = 8'h75;
    localparam logic [7:0] DOWN  = 8'h72;

    localparam int FRAME_BITS = 11;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_INH,
        BIT_HIGH,
        BIT_LOW,
        GAP,
        DONE
    } ps2_state_e;

    // Frame bit 0 goes out first: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_device_tx_if.sv
// Request handshake plus PS/2 pin bundle between a key-event source and the
// device-side transmitter. The master requests key events and owns the sensed
// bus clock; the slave (transmitter) drives the PS/2 lines and status.
interface ps2_device_tx_if;

    logic       send;
    logic [7:0] key_code;
    logic       extended;
    logic       key_release;
    logic       ps2_clk_in;
    logic       busy;
    logic       done;
    logic       ps2_clk_out;
    logic       ps2_dat_out;

    modport master (
        output send, key_code, extended, key_release, ps2_clk_in,
        input  busy, done, ps2_clk_out, ps2_dat_out
    );

    modport slave (
        input  send, key_code, extended, key_release, ps2_clk_in,
        output busy, done, ps2_clk_out, ps2_dat_out
    );

endinterface

// File: rtl/ps2_frame_shifter.sv
// Serializes one 11-bit PS/2 frame. Owns the half-period counter, the bit
// index and the frame shift register; the sequencer tells it which clock
// phase is current and it reports when a half period and the frame end.
module ps2_frame_shifter #(
    parameter int HALF_CYCLES = 2500,
    parameter int CNT_W       = 13
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        load_i,
    input  logic [10:0] frame_i,
    input  logic        run_i,
    input  logic        low_i,
    output logic        half_done_o,
    output logic        frame_done_o,
    output logic        dat_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [10:0]      frame_q, frame_d;

    assign half_done_o  = (cnt_q == CNT_W'(HALF_CYCLES - 1));
    assign frame_done_o = run_i && low_i && half_done_o && (bit_q == 4'd10);
    assign dat_o        = frame_q[0];

    // Counter, bit index and shift register next-state; a bit retires at the end of its low phase.
    always_comb begin
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        if (load_i) begin
            cnt_d   = '0;
            bit_d   = 4'd0;
            frame_d = frame_i;
        end else if (run_i) begin
            if (half_done_o) begin
                cnt_d = '0;
                if (low_i) begin
                    frame_d = {1'b1, frame_q[10:1]};
                    if (bit_q != 4'd10) begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Shifter state registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            bit_q   <= 4'd0;
            frame_q <= '1;
        end else begin
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
        end
    end

endmodule

// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter (keyboard emulator). Accepts one key event,
// builds the [E0][F0] code byte list and sends each byte as a frame,
// waiting out host inhibit before every start bit and idling between frames.
module ps2_device_tx
    import ps2_pkg::*;
#(
    parameter int HALF_CYCLES = 2500,
    parameter int GAP_CYCLES  = 5000
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    ps2_device_tx_if.slave bus
);

    localparam int CNT_MAX = (HALF_CYCLES > GAP_CYCLES) ? HALF_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    ps2_state_e       state_q, state_d;
    logic [3:0][7:0]  bytes_q, bytes_d;
    logic [1:0]       last_q, last_d;
    logic [1:0]       byte_q, byte_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic             sync1_q, sync2_q;

    logic             sh_load;
    logic             sh_run;
    logic             sh_low;
    logic             sh_half_done;
    logic             sh_frame_done;
    logic             sh_dat;

    assign sh_load = (state_q == WAIT_INH);
    assign sh_run  = (state_q == BIT_HIGH) || (state_q == BIT_LOW);
    assign sh_low  = (state_q == BIT_LOW);

    ps2_frame_shifter #(
        .HALF_CYCLES (HALF_CYCLES),
        .CNT_W       (CNT_W)
    ) u_shifter (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .load_i       (sh_load),
        .frame_i      (ps2_frame(bytes_q[byte_q])),
        .run_i        (sh_run),
        .low_i        (sh_low),
        .half_done_o  (sh_half_done),
        .frame_done_o (sh_frame_done),
        .dat_o        (sh_dat)
    );

    assign bus.busy        = (state_q != IDLE) && (state_q != DONE);
    assign bus.done        = (state_q == DONE);
    assign bus.ps2_clk_out = (state_q != BIT_LOW);
    assign bus.ps2_dat_out = sh_run ? sh_dat : 1'b1;

    // Sensed bus clock is asynchronous; two flops, idling high like the bus.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus.ps2_clk_in;
            sync2_q <= sync1_q;
        end
    end

    // Sequencer next-state: byte list build on accept, inhibit wait, phases, gap, done.
    always_comb begin
        state_d = state_q;
        bytes_d = bytes_q;
        last_d  = last_q;
        byte_d  = byte_q;
        gap_d   = '0;
        case (state_q)
            IDLE: begin
                if (bus.send) begin
                    bytes_d[0] = bus.extended ? PS2_EXT
                               : (bus.key_release ? PS2_BREAK : bus.key_code);
                    bytes_d[1] = (bus.extended && bus.key_release) ? PS2_BREAK : bus.key_code;
                    bytes_d[2] = bus.key_code;
                    bytes_d[3] = bus.key_code;
                    last_d     = {1'b0, bus.extended} + {1'b0, bus.key_release};
                    byte_d     = 2'd0;
                    state_d    = WAIT_INH;
                end
            end
            WAIT_INH: begin
                if (sync2_q) begin
                    state_d = BIT_HIGH;
                end
            end
            BIT_HIGH: begin
                if (sh_half_done) begin
                    state_d = BIT_LOW;
                end
            end
            BIT_LOW: begin
                if (sh_half_done) begin
                    state_d = sh_frame_done ? GAP : BIT_HIGH;
                end
            end
            GAP: begin
                if (gap_q == CNT_W'(GAP_CYCLES - 1)) begin
                    if (byte_q == last_q) begin
                        state_d = DONE;
                    end else begin
                        byte_d  = byte_q + 2'd1;
                        state_d = WAIT_INH;
                    end
                end else begin
                    gap_d = gap_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state registers; reset drops any frame in flight.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bytes_q <= '0;
            last_q  <= 2'd0;
            byte_q  <= 2'd0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            bytes_q <= bytes_d;
            last_q  <= last_d;
            byte_q  <= byte_d;
            gap_q   <= gap_d;
        end
    end

endmodule

// File: doc/ps2_device_tx.md
Name: ps2_device_tx

Overview:
- Synthesizable PS/2 device-side transmitter, acting as a keyboard emulator.
- Serializes a make/break scan-code sequence onto PS2_CLK/PS2_DAT as correct 11-bit device-to-host frames.
- Its pins feed the top's PS/2 receiver in benches and board self-test, replacing ad-hoc pin wiggling.
- Accepts one key event per request and emits the optional E0 prefix, the optional F0 break prefix, then the code byte.

Parameters:
- HALF_CYCLES, 2500, CLOCK_50 cycles per PS/2 clock half-period (10 kHz at 50 MHz); benches use 4.
- GAP_CYCLES, 5000, idle cycles (clock and data high) after every frame; benches use 8.

Ports:
- CLOCK_50 input 1 system clock, rising edge.
- reset input 1 asynchronous, active-high.
- send input 1 one-cycle request; sampled only when busy=0.
- key_code input 8 scan code (e.g. 8'h6B left, 8'h74 right, 8'h75 up, 8'h72 down).
- extended input 1 prepend 8'hE0.
- release input 1 prepend 8'hF0 (after E0 if both are set).
- ps2_clk_in input 1 sensed bus clock, used for host-inhibit detection; asynchronous.
- busy output 1 sequence in progress.
- done output 1 one-cycle pulse when the sequence completes.
- ps2_clk_out output 1 driven PS/2 clock; idle 1.
- ps2_dat_out output 1 driven PS/2 data; idle 1.

Behaviour:
- Reset values:
  - busy=0, done=0, ps2_clk_out=1, ps2_dat_out=1.
  - FSM=IDLE; all counters 0.
  - Reset mid-frame forces these values immediately (asynchronous). No partial frame resumes after reset.
- Accept: in IDLE, when send=1 at a rising edge:
  - latch key_code, extended and release;
  - build the byte list [E0][F0] code (1 to 3 bytes);
  - busy=1 from the next cycle.
  - send while busy=1 is ignored (no queueing).
- ps2_clk_in passes through a 2-flop synchronizer.
- FSM states:
  - IDLE.
  - WAIT_INH: if the synced clock is low, stay (host inhibit). Go to BIT_HIGH on the first cycle the synced clock is seen high. Checked only before each frame's start bit, never mid-frame.
  - BIT_HIGH: ps2_clk_out=1, ps2_dat_out=frame[i], held HALF_CYCLES cycles.
  - BIT_LOW: ps2_clk_out=0, data held, HALF_CYCLES cycles. Then i++; if i was 10, go to GAP, else go to BIT_HIGH.
  - GAP: both lines 1 for GAP_CYCLES cycles. Then go to WAIT_INH for the next byte, or DONE if this was the last byte.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Frame bits, i=0..10:
  - start bit 0;
  - data bits d0..d7, LSB first;
  - odd parity bit = ~^byte;
  - stop bit 1.
- Data changes only while the clock is high. The host samples on falling edges, so there are exactly 11 falling edges per byte.
- Per-byte duration from the first BIT_HIGH cycle: 22*HALF_CYCLES + GAP_CYCLES cycles.
- Counter widths: half-cycle counter $clog2(max(HALF_CYCLES,GAP_CYCLES)+1); bit index 4 bits; byte index 2 bits.
- A new send is accepted in the cycle after DONE.

Decomposition:
- Shared package ps2_pkg holds:
  - PS2_EXT=8'hE0 and PS2_BREAK=8'hF0;
  - arrow codes LEFT=8'h6B, RIGHT=8'h74, UP=8'h75, DOWN=8'h72;
  - FSM state enum;
  - frame-build function {1'b1, ~^b, b, 1'b0}.
- One natural sub-module, ps2_frame_shifter: serializes one 11-bit frame with the clock-phase counter and reports frame_done. ps2_device_tx sequences bytes, handles inhibit and does the handshake.

Test Plan (HALF_CYCLES=4, GAP_CYCLES=8):
- Reset asserted mid-frame (during a BIT_LOW phase) -> next sampled ps2_clk_out=1, ps2_dat_out=1, busy=0; a following send 8'h72 produces one clean frame 0,0,1,0,0,1,1,1,0,1,1.
- send, key_code=8'h6B, extended=0, release=0 ->
  - 11 falling edges;
  - bits sampled at the falls: 0,1,1,0,1,0,1,1,0,0,1 (parity 0);
  - busy high for 1 + 96 cycles, then a single done pulse.
- send 8'h74 with extended=1, release=1 ->
  - frames E0 (parity 0), F0 (parity 1), 74 (parity 1), in order;
  - 33 falling edges;
  - exactly one done pulse, after the third gap.
- ps2_clk_in held 0 during the request, released 20 cycles later -> no falling edge on ps2_clk_out before the release plus 2 synchronizer cycles, then a normal 0x75 frame (parity 0).
- Second send pulse while busy=1 -> ignored; only the first sequence is emitted. A send on the cycle after done -> accepted.
